req_qos_arbiter: RTL and testbench

Quality-of-service arbiter that shares the single `req_sdram` port between the CPU path and the VGA `req_dma` fetch engine. It replaces plain rotation with urgency-aware granting: a master flagging `m_urgent` (the DMA when its pixel buffer runs low) wins the next slot, otherwise grants rotate round-robin. It owns the slave for one whole transaction (request plus all data beats) and steers write/read beats to and from the owner.

---
 rtl/req_qos_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_req_qos_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_qos_arbiter.sv
// QoS arbiter sharing one SDRAM request port between the CPU (lane 0) and DMA lanes.
// Define QOS_ARB_STARVE_EN to add per-master starvation counters that override urgency.
module req_qos_arbiter #(
  parameter int MASTERS    = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MASTERS-1:0]      m_req_valid,
  output logic [MASTERS-1:0]      m_req_ready,
  input  logic [3*MASTERS-1:0]    m_req_len,
  input  logic [4*MASTERS-1:0]    m_req_mask,
  input  logic [32*MASTERS-1:0]   m_req_addr,
  input  logic [MASTERS-1:0]      m_req_we,
  input  logic [MASTERS-1:0]      m_urgent,
  input  logic [MASTERS-1:0]      m_write_valid,
  input  logic [32*MASTERS-1:0]   m_write_data,
  output logic [MASTERS-1:0]      m_read_valid,
  output logic [32*MASTERS-1:0]   m_read_data,
  input  logic [MASTERS-1:0]      m_read_ack,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [2:0]              req_len,
  output logic [3:0]              req_mask,
  output logic [31:0]             req_addr,
  output logic                    req_we,
  output logic                    write_valid,
  output logic [31:0]             write_data,
  input  logic                    read_valid,
  input  logic [31:0]             read_data,
  output logic                    read_ack,
  output logic [MASTERS-1:0]      grant
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  if (MASTERS < 1 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("req_qos_arbiter: MASTERS must be >= 1 and STARVE_MAX within 1..15");
  end

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_q;
  logic [MASTERS-1:0] grant_q;
  logic [2:0]         len_q;
  logic [2:0]         cnt_q;
  logic               we_q;
  logic               beat;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [2:0]         win_len;
  logic               win_we;

  logic               own_req_valid;
  logic [2:0]         own_len;
  logic [3:0]         own_mask;
  logic [31:0]        own_addr;
  logic               own_we;
  logic               own_write_valid;
  logic [31:0]        own_write_data;
  logic               own_read_ack;

`ifdef QOS_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q [MASTERS];

  // Counters move only on an IDLE grant: losers that were waiting age, everyone else clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small array is real arbitration state, so it is reset like any
      // register; large data memories would normally be left unreset.
      for (int i = 0; i < MASTERS; i++) starve_q[i] <= '0;
    end else if (state_q == IDLE && win_found) begin
      for (int i = 0; i < MASTERS; i++) begin
        if (IDX_W'(i) == win_idx || !m_req_valid[i]) starve_q[i] <= '0;
        else if (starve_q[i] != 4'hF)               starve_q[i] <= starve_q[i] + 4'd1;
      end
    end
  end
`endif

  // Winner: starved (optional) > urgent > round-robin from the lane after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_len   = '0;
    win_we    = 1'b0;
`ifdef QOS_ARB_STARVE_EN
    for (int i = 0; i < MASTERS; i++)
      if (!win_found && m_req_valid[i] && starve_q[i] >= STARVE_LIM) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
`endif
    for (int i = 0; i < MASTERS; i++)
      if (!win_found && m_req_valid[i] && m_urgent[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    for (int i = 0; i < MASTERS; i++)
      if (!win_found && m_req_valid[i] && IDX_W'(i) > rr_q) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    for (int i = 0; i < MASTERS; i++)
      if (!win_found && m_req_valid[i] && IDX_W'(i) <= rr_q) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    for (int i = 0; i < MASTERS; i++)
      if (win_idx == IDX_W'(i)) begin
        win_len = m_req_len[3*i +: 3];
        win_we  = m_req_we[i];
      end
  end

  // Owner lane selection; every field defaults to 0 so nothing latches.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first;
    // a path that skips an assignment would otherwise infer a latch.
    own_req_valid   = 1'b0;
    own_len         = '0;
    own_mask        = '0;
    own_addr        = '0;
    own_we          = 1'b0;
    own_write_valid = 1'b0;
    own_write_data  = '0;
    own_read_ack    = 1'b0;
    for (int i = 0; i < MASTERS; i++)
      if (owner_q == IDX_W'(i)) begin
        own_req_valid   = m_req_valid[i];
        own_len         = m_req_len[3*i +: 3];
        own_mask        = m_req_mask[4*i +: 4];
        own_addr        = m_req_addr[32*i +: 32];
        own_we          = m_req_we[i];
        own_write_valid = m_write_valid[i];
        own_write_data  = m_write_data[32*i +: 32];
        own_read_ack    = m_read_ack[i];
      end
  end

  always_comb begin
    state_d      = state_q;
    m_req_ready  = '0;
    m_read_valid = '0;
    req_valid    = 1'b0;
    req_len      = '0;
    req_mask     = '0;
    req_addr     = '0;
    req_we       = 1'b0;
    write_valid  = 1'b0;
    write_data   = '0;
    read_ack     = 1'b0;
    beat         = 1'b0;
    case (state_q)
      IDLE: if (win_found) state_d = REQ;
      REQ: begin
        req_valid   = own_req_valid;
        req_len     = own_len;
        req_mask    = own_mask;
        req_addr    = own_addr;
        req_we      = own_we;
        m_req_ready = grant_q & {MASTERS{req_ready}};
        if (own_req_valid && req_ready) state_d = DATA;
      end
      DATA: begin
        if (we_q) begin
          write_valid = own_write_valid;
          write_data  = own_write_data;
          beat        = own_write_valid;
        end else begin
          m_read_valid = grant_q & {MASTERS{read_valid}};
          read_ack     = own_read_ack;
          beat         = read_valid && own_read_ack;
        end
        if (beat && cnt_q == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= IDX_W'(MASTERS - 1);
      grant_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (win_found) begin
          owner_q <= win_idx;
          grant_q <= MASTERS'(1) << win_idx;
          len_q   <= win_len;
          we_q    <= win_we;
        end
        REQ: if (own_req_valid && req_ready) begin
          cnt_q <= len_q;
          rr_q  <= owner_q;
        end
        DATA: if (beat) begin
          if (cnt_q == 3'd0) grant_q <= '0;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign grant       = grant_q;
  assign m_read_data = {MASTERS{read_data}};

endmodule

// File: tb/tb_req_qos_arbiter.sv
// Self-checking bench for req_qos_arbiter: vector table, directed corner cases and
// randomized traffic compared against a transaction-level arbitration model.
module tb_req_qos_arbiter;
  localparam int M          = 2;
  localparam int STARVE_MAX = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [M-1:0]      m_req_valid, m_req_ready, m_req_we, m_urgent;
  logic [3*M-1:0]    m_req_len;
  logic [4*M-1:0]    m_req_mask;
  logic [32*M-1:0]   m_req_addr;
  logic [M-1:0]      m_write_valid, m_read_valid, m_read_ack;
  logic [32*M-1:0]   m_write_data, m_read_data;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_len;
  logic [3:0]        req_mask;
  logic [31:0]       req_addr;
  logic              write_valid, read_valid, read_ack;
  logic [31:0]       write_data, read_data;
  logic [M-1:0]      grant;

  req_qos_arbiter #(.MASTERS(M), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_len(m_req_len),
    .m_req_mask(m_req_mask), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_urgent(m_urgent), .m_write_valid(m_write_valid), .m_write_data(m_write_data),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data), .m_read_ack(m_read_ack),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_mask(req_mask),
    .req_addr(req_addr), .req_we(req_we), .write_valid(write_valid), .write_data(write_data),
    .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack), .grant(grant)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0]  l_len   [M];
  logic        l_we    [M];
  logic [31:0] l_addr  [M];
  logic [3:0]  l_mask  [M];
  logic [31:0] l_wbase [M];

  task automatic set_lane(input int m, input logic [2:0] len, input logic we,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wbase);
    l_len[m] = len; l_we[m] = we; l_addr[m] = addr; l_mask[m] = mask; l_wbase[m] = wbase;
    m_req_len[3*m +: 3]   = len;
    m_req_we[m]           = we;
    m_req_addr[32*m +: 32] = addr;
    m_req_mask[4*m +: 4]  = mask;
  endtask

  // Reference model: arbitration rules applied per grant decision.
  int last_owner;
  int starve_cnt [M];

  task automatic model_reset();
    last_owner = M - 1;
    for (int i = 0; i < M; i++) starve_cnt[i] = 0;
  endtask

  function automatic int model_pick(input logic [M-1:0] v, input logic [M-1:0] u);
`ifdef QOS_ARB_STARVE_EN
    for (int i = 0; i < M; i++) if (v[i] && starve_cnt[i] >= STARVE_MAX) return i;
`endif
    for (int i = 0; i < M; i++) if (v[i] && u[i]) return i;
    for (int k = 1; k <= M; k++) if (v[(last_owner + k) % M]) return (last_owner + k) % M;
    return -1;
  endfunction

  task automatic model_commit(input logic [M-1:0] v, input int w);
    for (int i = 0; i < M; i++) begin
      if (i == w || !v[i]) starve_cnt[i] = 0;
      else if (starve_cnt[i] < 15) starve_cnt[i]++;
    end
    last_owner = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req_valid = '0; m_urgent = '0; m_write_valid = '0; m_write_data = '0; m_read_ack = '0;
    req_ready = 1'b0; read_valid = 1'b0; read_data = '0;
    for (int i = 0; i < M; i++) set_lane(i, 3'd0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic arbitrate(input logic [M-1:0] v, input logic [M-1:0] u,
                           input logic [M-1:0] exp_grant, input string tag);
    int w = 0;
    m_req_valid = v;
    m_urgent    = u;
    tick();
    #1;
    check({tag, " grant"}, 64'(grant), 64'(exp_grant));
    for (int i = 0; i < M; i++) if (exp_grant[i]) w = i;
    if (exp_grant != '0)
      check({tag, " req fields"}, 64'({req_valid, req_we, req_len, req_mask, req_addr}),
            64'({1'b1, l_we[w], l_len[w], l_mask[w], l_addr[w]}));
  endtask

  task automatic handshake(input int w, input int delay, input string tag);
    int mism = 0;
    req_ready = 1'b0;
    for (int d = 0; d < delay; d++) begin
      #1;
      if (m_req_ready !== '0 || req_valid !== 1'b1) mism++;
      tick();
    end
    req_ready = 1'b1;
    #1;
    if (m_req_ready !== (M'(1) << w)) mism++;
    check({tag, " req handshake"}, 64'(mism), 64'(0));
    tick();
    req_ready      = 1'b0;
    m_req_valid[w] = 1'b0;
  endtask

  // Drives the owner's beats (write) or the slave's beats (read) and checks steering.
  task automatic data_phase(input int w, input bit rnd, input int stall_at,
                            input int stop_after, input string tag);
    int beats = 0, seen = 0, mism = 0, cyc = 0, stall_left = 0;
    bit stalled = 1'b0;
    bit drv, ack;
    logic [31:0] rd;
    int need = int'(l_len[w]) + 1;
    while (beats < need && cyc < 200 && !(stop_after >= 0 && beats == stop_after)) begin
      drv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ack = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_at == beats && !stalled) begin stall_left = 3; stalled = 1'b1; end
      if (stall_left > 0) begin ack = 1'b0; stall_left--; end
      if (l_we[w]) begin
        for (int i = 0; i < M; i++) begin
          m_write_valid[i]          = 1'($urandom_range(0, 1));
          m_write_data[32*i +: 32]  = $urandom;
        end
        m_write_valid[w]         = drv;
        m_write_data[32*w +: 32] = l_wbase[w] + 32'(beats);
        #1;
        if (write_valid !== drv) mism++;
        if (drv && write_data !== l_wbase[w] + 32'(beats)) mism++;
        if (write_valid === 1'b1) seen++;
        if (drv) beats++;
      end else begin
        rd         = $urandom;
        read_valid = drv;
        read_data  = rd;
        m_read_ack = M'($urandom_range(0, 3));
        m_read_ack[w] = ack;
        #1;
        if (m_read_valid !== (drv ? (M'(1) << w) : M'(0))) mism++;
        if (read_ack !== ack) mism++;
        if (m_read_data !== {M{rd}}) mism++;
        if (read_valid && read_ack === 1'b1) seen++;
        if (drv && ack) beats++;
      end
      tick();
      cyc++;
    end
    m_write_valid = '0;
    read_valid    = 1'b0;
    m_read_ack    = '0;
    check({tag, " steering"}, 64'(mism), 64'(0));
    if (stop_after < 0) begin
      check({tag, " beats"}, 64'(seen), 64'(need));
      #1;
      check({tag, " back to idle"}, 64'({grant, req_valid, write_valid, read_ack}), 64'(0));
    end
  endtask

  task automatic txn(input logic [M-1:0] v, input logic [M-1:0] u, input logic [M-1:0] exp_grant,
                     input bit rnd, input int delay, input string tag);
    int w = 0;
    arbitrate(v, u, exp_grant, tag);
    if (exp_grant != '0) begin
      for (int i = 0; i < M; i++) if (exp_grant[i]) w = i;
      handshake(w, delay, tag);
      data_phase(w, rnd, -1, -1, tag);
    end
  endtask

  typedef struct {
    logic [M-1:0] v;
    logic [M-1:0] u;
    logic [M-1:0] exp_grant;
  } arb_vec_t;

  arb_vec_t tbl [11];

  initial begin
    int mism;
    logic [M-1:0] pend, urg, exp_g;
    int w;

    tbl[0]  = '{2'b11, 2'b00, 2'b01};
    tbl[1]  = '{2'b11, 2'b00, 2'b10};
    tbl[2]  = '{2'b11, 2'b10, 2'b10};
    tbl[3]  = '{2'b10, 2'b00, 2'b10};
    tbl[4]  = '{2'b11, 2'b00, 2'b01};
    tbl[5]  = '{2'b01, 2'b00, 2'b01};
    tbl[6]  = '{2'b11, 2'b11, 2'b01};
    tbl[7]  = '{2'b11, 2'b01, 2'b01};
    tbl[8]  = '{2'b00, 2'b00, 2'b00};
    tbl[9]  = '{2'b01, 2'b10, 2'b01};
    tbl[10] = '{2'b11, 2'b00, 2'b10};

    // Reset values and a quiet idle period.
    do_reset();
    #1;
    check("reset ctrl", 64'({m_req_ready, m_read_valid, req_valid, write_valid, read_ack, grant,
                             req_len, req_mask, req_we, req_addr}), 64'(0));
    check("reset write_data", 64'(write_data), 64'(0));
    mism = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      if ({m_req_ready, m_read_valid, req_valid, write_valid, read_ack, grant} !== '0) mism++;
    end
    check("idle 20 cycles", 64'(mism), 64'(0));

    // CPU single write.
    set_lane(0, 3'd0, 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
    txn(2'b01, 2'b00, 2'b01, 1'b0, 0, "cpu_write");

    // Arbitration vector table, single-beat reads.
    do_reset();
    set_lane(0, 3'd0, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    set_lane(1, 3'd0, 1'b0, 32'h0000_2000, 4'h3, 32'h0);
    for (int i = 0; i < 11; i++)
      txn(tbl[i].v, tbl[i].u, tbl[i].exp_grant, 1'b0, 0, $sformatf("vec%0d", i));

    // Round-robin alternation with 4-beat reads and random gaps.
    do_reset();
    set_lane(0, 3'd3, 1'b0, 32'h0000_3000, 4'hF, 32'h0);
    set_lane(1, 3'd3, 1'b0, 32'h0000_4000, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++)
      txn(2'b11, 2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, k % 3, $sformatf("rr%0d", k));

    // Continuously urgent DMA against a waiting CPU.
    do_reset();
    set_lane(0, 3'd0, 1'b0, 32'h0000_5000, 4'hF, 32'h0);
    set_lane(1, 3'd0, 1'b0, 32'h0000_6000, 4'hF, 32'h0);
    for (int k = 0; k < 16; k++) begin
`ifdef QOS_ARB_STARVE_EN
      exp_g = (k == 15) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      txn(2'b11, 2'b10, exp_g, 1'b0, 0, $sformatf("urgent%0d", k));
    end

    // Owner withholds m_read_ack for 3 cycles mid-burst.
    do_reset();
    set_lane(0, 3'd7, 1'b0, 32'h0000_7000, 4'hF, 32'h0);
    arbitrate(2'b01, 2'b00, 2'b01, "stall");
    handshake(0, 1, "stall");
    data_phase(0, 1'b0, 3, -1, "stall");

    // Reset after 2 of 8 read beats, then a fresh CPU write.
    do_reset();
    set_lane(0, 3'd7, 1'b0, 32'h0000_8000, 4'hF, 32'h0);
    arbitrate(2'b01, 2'b00, 2'b01, "abort");
    handshake(0, 0, "abort");
    data_phase(0, 1'b0, -1, 2, "abort");
    read_valid  = 1'b1;
    m_read_ack  = '1;
    m_req_valid = '1;
    rst = 1'b1;
    tick();
    #1;
    check("abort reset outputs", 64'({m_req_ready, m_read_valid, req_valid, write_valid, read_ack, grant}), 64'(0));
    rst = 1'b0;
    read_valid = 1'b0; m_read_ack = '0; m_req_valid = '0;
    model_reset();
    set_lane(0, 3'd1, 1'b1, 32'h0000_9000, 4'hC, 32'hCAFE_0000);
    txn(2'b01, 2'b00, 2'b01, 1'b0, 0, "after_abort");

    // Randomized traffic against the reference model.
    do_reset();
    pend = '0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < M; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_lane(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                   4'($urandom_range(0, 15)), $urandom);
          pend[i] = 1'b1;
        end
      urg   = M'($urandom_range(0, 3)) & M'($urandom_range(0, 3));
      w     = model_pick(pend, urg);
      exp_g = (w < 0) ? M'(0) : (M'(1) << w);
      arbitrate(pend, urg, exp_g, $sformatf("rnd%0d", r));
      if (w >= 0) begin
        handshake(w, $urandom_range(0, 2), $sformatf("rnd%0d", r));
        data_phase(w, 1'b1, -1, -1, $sformatf("rnd%0d", r));
        model_commit(pend, w);
        pend[w] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
